// File: rtl/seq_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier_if
// Description : Start/busy/done handshake bundle for the iterative multiplier.
//               It carries the two register-file operands in and the HI/LO
//               product out.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dataout1;
  logic [WIDTH-1:0] dataout2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline control side: issues requests and consumes results
  modport master (
    output start, is_signed, dataout1, dataout2,
    input  busy, done, hi, lo
  );

  // Multiplier side
  modport slave (
    input  start, is_signed, dataout1, dataout2,
    output busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : Iterative shift-add multiplier for MULT/MULTU. It works on
//               operand magnitudes, performs one add-and-shift per cycle for
//               WIDTH cycles, then applies the sign and writes HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  seq_multiplier_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;      // accumulator, becomes the product's upper half
  logic [WIDTH-1:0]   r_q;      // multiplier, shifted out as product bits shift in
  logic [WIDTH-1:0]   r_m;      // multiplicand magnitude
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic               w_neg;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_result;
  logic               w_last;

  // Operand magnitudes and sign, plus the per-cycle add step and final negate.
  // The most negative value maps to itself, which is the correct unsigned
  // magnitude, so no overflow handling is needed.
  always_comb begin
    w_mag1   = bus.dataout1;
    w_mag2   = bus.dataout2;
    w_neg    = 1'b0;
    if (bus.is_signed) begin
      if (bus.dataout1[WIDTH-1]) w_mag1 = ~bus.dataout1 + WIDTH'(1);
      if (bus.dataout2[WIDTH-1]) w_mag2 = ~bus.dataout2 + WIDTH'(1);
      w_neg = bus.dataout1[WIDTH-1] ^ bus.dataout2[WIDTH-1];
    end
    w_sum    = {1'b0, r_a} + (r_q[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
    w_prod   = {r_a, r_q};
    w_result = r_neg ? (~w_prod + (2*WIDTH)'(1)) : w_prod;
    w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  end

  // Control FSM and datapath registers; busy/done/hi/lo are all registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_m     <= w_mag1;
            r_q     <= w_mag2;
            r_neg   <= w_neg;
            r_a     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          // Shift {carry, sum, Q} right by one: the sum's LSB enters Q's MSB
          r_a   <= w_sum[WIDTH:1];
          r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) r_state <= S_FINISH;
        end
        S_FINISH: begin
          r_hi    <= w_result[2*WIDTH-1:WIDTH];
          r_lo    <= w_result[WIDTH-1:0];
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_multiplier
// Description : Self-checking bench for seq_multiplier. It uses a vector table
//               and a result scoreboard, plus hand-written handshake and
//               reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

  logic clk;
  logic rst_n;

  seq_multiplier_if #(.WIDTH(32)) bus ();

  seq_multiplier #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [63:0]   sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference product: sign- or zero-extend to 64 bits and keep the low 64 bits
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = s ? {{32{a[31]}}, a} : {32'h0, a};
    eb = s ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  // Scoreboard consumer: every done pulse pops and compares one expected result
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        check("result", {bus.hi, bus.lo}, sb.pop_front());
        check("busy_in_done", {63'd0, bus.busy}, 64'd0);
      end
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.done && n < 200);
  endtask

  // Issues one multiply from IDLE, checks latency, then checks that HI/LO hold
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = s;
    bus.dataout1  = a;
    bus.dataout2  = b;
    sb.push_back({ehi, elo});
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.is_signed = $urandom_range(0, 1);
    bus.dataout1  = $urandom;
    bus.dataout2  = $urandom;
    check("busy_after_start", {63'd0, bus.busy}, 64'd1);
    wait_done(n);
    check("latency", 64'(n), 64'd33);
    @(posedge clk);
    #1;
    check("hold_after_done", {bus.hi, bus.lo}, {ehi, elo});
  endtask

  vec_t vecs[10];
  vec_t rv;
  int   n;
  int   ndone;
  logic [63:0] exp_a;
  logic [63:0] exp_b;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 32'h00000001, 32'h00000002, 32'h00000000, 32'h00000002};
    vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{1'b0, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
    vecs[3] = '{1'b1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[4] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[5] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[6] = '{1'b0, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    vecs[7] = '{1'b1, 32'h00000007, 32'hFFFFFFF7, 32'hFFFFFFFF, 32'hFFFFFFC1};
    vecs[8] = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
    vecs[9] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};

    // Reset state
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dataout1  = '0;
    bus.dataout2  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 10; i++)
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // Random vectors against the reference model
    for (int i = 0; i < 4; i++) begin
      rv.s = $urandom_range(0, 1);
      rv.a = $urandom;
      rv.b = $urandom;
      exp_a = model(rv.s, rv.a, rv.b);
      run_op(rv.s, rv.a, rv.b, exp_a[63:32], exp_a[31:0]);
    end

    // Handshake: start at E10 is ignored, start in the done cycle is accepted
    exp_a = model(1'b0, 32'h00012345, 32'h00067890);
    exp_b = model(1'b1, 32'hFFFF0000, 32'h00001234);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.dataout1  = 32'h00012345;
    bus.dataout2  = 32'h00067890;
    sb.push_back(exp_a);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    bus.start     = 1'b1;
    bus.is_signed = 1'b1;
    bus.dataout1  = 32'hDEADBEEF;
    bus.dataout2  = 32'h00000003;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(n);
    check("latency_ignored_start", 64'(n + 10), 64'd33);
    bus.start     = 1'b1;
    bus.is_signed = 1'b1;
    bus.dataout1  = 32'hFFFF0000;
    bus.dataout2  = 32'h00001234;
    sb.push_back(exp_b);
    repeat (5) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    check("hold_during_calc", {bus.hi, bus.lo}, exp_a);
    wait_done(n);
    check("done_to_done", 64'(n + 5), 64'd34);
    @(posedge clk);
    #1;

    // Reset in the middle of 7 x 9
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.dataout1  = 32'd7;
    bus.dataout2  = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("midreset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) ndone++;
    end
    check("no_activity_after_reset", 64'(ndone), 64'd0);
    run_op(1'b0, 32'd7, 32'd9, 32'd0, 32'd63);

    repeat (2) @(posedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
